// File: rtl/tile_pkg.sv
// Shared types and constants for the layer tile scheduler.
package tile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DRAIN
  } sched_state_t;

  localparam int NUM_TILE_BUFS      = 2;
  localparam int DEFAULT_BUF_STRIDE = 32;

endpackage

// File: rtl/tile_buf_tracker.sv
// Ping-pong tile buffer bookkeeping: write/read pointers, fill count, row tags
// and the sticky error raised by a release while nothing is filled.
module tile_buf_tracker
  import tile_pkg::*;
#(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             commit,
  input  logic             tile_release,
  input  logic [ROW_W-1:0] commit_row,
  output logic             wr_buf,
  output logic             rd_buf,
  output logic [1:0]       fill_cnt,
  output logic [ROW_W-1:0] tile_row,
  output logic             err
);

  logic             rel_ok;
  logic [ROW_W-1:0] row_tag [NUM_TILE_BUFS];

  // A release with nothing filled is dropped and only flags the error.
  assign rel_ok   = tile_release && (fill_cnt != 2'd0);
  assign tile_row = row_tag[rd_buf];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_buf   <= 1'b0;
      rd_buf   <= 1'b0;
      fill_cnt <= 2'd0;
      err      <= 1'b0;
      for (int i = 0; i < NUM_TILE_BUFS; i++) row_tag[i] <= '0;
    end else if (clear) begin
      wr_buf   <= 1'b0;
      rd_buf   <= 1'b0;
      fill_cnt <= 2'd0;
      err      <= 1'b0;
      for (int i = 0; i < NUM_TILE_BUFS; i++) row_tag[i] <= '0;
    end else begin
      if (commit) begin
        wr_buf          <= ~wr_buf;
        row_tag[wr_buf] <= commit_row;
      end
      if (rel_ok) rd_buf <= ~rd_buf;
      case ({commit, rel_ok})
        2'b10:   fill_cnt <= fill_cnt + 2'd1;
        2'b01:   fill_cnt <= fill_cnt - 2'd1;
        default: fill_cnt <= fill_cnt;
      endcase
      if (tile_release && (fill_cnt == 2'd0)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks the tile rows of a layer, programming and starting the mover once per
// row while keeping it from overrunning the two-entry tile buffer.
module tile_scheduler
  import tile_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_W      = 8,
  parameter int BUF_STRIDE = DEFAULT_BUF_STRIDE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  go,
  input  logic [ROW_W-1:0]      cfg_num_rows,
  input  logic [ADDR_WIDTH-1:0] cfg_rd_base,
  input  logic [ADDR_WIDTH-1:0] cfg_row_step,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_base,
  input  logic [5:0]            cfg_row_len,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_chan,
  input  logic [9:0]            cfg_chan_num,
  output logic                  mover_start,
  output logic                  mover_clr,
  output logic [5:0]            mover_row_len,
  output logic [ADDR_WIDTH-1:0] mover_base_addr_rd,
  output logic [ADDR_WIDTH-1:0] mover_base_addr_wr,
  output logic [ADDR_WIDTH-1:0] mover_stride_chan,
  output logic [9:0]            mover_chan_num,
  input  logic                  mover_done,
  output logic                  tile_valid,
  output logic                  tile_buf,
  output logic [ROW_W-1:0]      tile_row,
  input  logic                  tile_release,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BUF_OFS = ADDR_WIDTH'(BUF_STRIDE);

  sched_state_t          state;
  logic                  done_q;
  logic                  commit;
  logic                  go_accept;
  logic                  trk_clear;
  logic [ROW_W-1:0]      num_rows_reg;
  logic [ROW_W-1:0]      row_idx;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] row_step_reg;
  logic [ADDR_WIDTH-1:0] wr_base_reg;
  logic                  wr_buf;
  logic                  rd_buf;
  logic [1:0]            fill_cnt;

  // The mover's done level lingers from the previous row, so only a fresh
  // rising edge while waiting counts as completion.
  assign commit    = mover_done && !done_q && (state == WAIT);
  assign go_accept = go && (state == IDLE);
  assign trk_clear = clr || go_accept;

  assign mover_start        = (state == ISSUE);
  assign busy               = (state != IDLE);
  assign layer_done         = (state == DRAIN) && (fill_cnt == 2'd0);
  assign tile_valid         = (fill_cnt != 2'd0);
  assign tile_buf           = rd_buf;
  assign mover_base_addr_rd = rd_ptr;
  assign mover_base_addr_wr = wr_base_reg + (wr_buf ? BUF_OFS : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      done_q            <= 1'b0;
      mover_clr         <= 1'b0;
      num_rows_reg      <= '0;
      row_idx           <= '0;
      rd_ptr            <= '0;
      row_step_reg      <= '0;
      wr_base_reg       <= '0;
      mover_row_len     <= '0;
      mover_stride_chan <= '0;
      mover_chan_num    <= '0;
    end else if (clr) begin
      state             <= IDLE;
      done_q            <= 1'b0;
      mover_clr         <= 1'b1;
      num_rows_reg      <= '0;
      row_idx           <= '0;
      rd_ptr            <= '0;
      row_step_reg      <= '0;
      wr_base_reg       <= '0;
      mover_row_len     <= '0;
      mover_stride_chan <= '0;
      mover_chan_num    <= '0;
    end else begin
      mover_clr <= 1'b0;
      done_q    <= mover_done;
      case (state)
        IDLE: begin
          if (go) begin
            num_rows_reg      <= cfg_num_rows;
            row_step_reg      <= cfg_row_step;
            wr_base_reg       <= cfg_wr_base;
            mover_row_len     <= cfg_row_len;
            mover_stride_chan <= cfg_stride_chan;
            mover_chan_num    <= cfg_chan_num;
            rd_ptr            <= cfg_rd_base;
            row_idx           <= '0;
            state             <= CHECK;
          end
        end
        CHECK: begin
          if (row_idx == num_rows_reg) state <= DRAIN;
          else if (fill_cnt < 2'd2)    state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (commit) begin
            row_idx <= row_idx + ROW_W'(1);
            rd_ptr  <= rd_ptr + row_step_reg;
            state   <= CHECK;
          end
        end
        DRAIN: begin
          if (fill_cnt == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tile_buf_tracker #(
    .ROW_W(ROW_W)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (trk_clear),
    .commit      (commit),
    .tile_release(tile_release),
    .commit_row  (row_idx),
    .wr_buf      (wr_buf),
    .rd_buf      (rd_buf),
    .fill_cnt    (fill_cnt),
    .tile_row    (tile_row),
    .err         (err)
  );

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench: expected mover programs and tile tags are queued by the
// stimulus and checked by monitor and consumer processes as the DUT emits them.
module tb_tile_scheduler;

  typedef struct {
    logic [7:0] rd;
    logic [7:0] wr;
  } start_t;

  typedef struct {
    logic [7:0] row;
    logic       bidx;
  } tile_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       go = 1'b0;
  logic [7:0] cfg_num_rows = '0;
  logic [7:0] cfg_rd_base = '0;
  logic [7:0] cfg_row_step = '0;
  logic [7:0] cfg_wr_base = '0;
  logic [5:0] cfg_row_len = '0;
  logic [7:0] cfg_stride_chan = '0;
  logic [9:0] cfg_chan_num = '0;
  logic       mover_done;
  logic       tile_release;

  wire        mover_start, mover_clr, tile_valid, tile_buf, busy, layer_done, err;
  wire [5:0]  mover_row_len;
  wire [7:0]  mover_base_addr_rd, mover_base_addr_wr, mover_stride_chan, tile_row;
  wire [9:0]  mover_chan_num;
  wire [63:0] all_outs = {9'd0, mover_start, mover_clr, mover_row_len, mover_base_addr_rd,
                          mover_base_addr_wr, mover_stride_chan, mover_chan_num,
                          tile_valid, tile_buf, tile_row, busy, layer_done, err};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int rel_at_cyc = -1;
  int mover_lat = 3;
  int stale_hold = 0;
  bit auto_rel = 1'b0;
  logic [5:0] cur_len = '0;
  logic [7:0] cur_stride = '0;
  logic [9:0] cur_chan = '0;

  start_t exp_start[$];
  tile_t  exp_tile[$];

  tile_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clr               (clr),
    .go                (go),
    .cfg_num_rows      (cfg_num_rows),
    .cfg_rd_base       (cfg_rd_base),
    .cfg_row_step      (cfg_row_step),
    .cfg_wr_base       (cfg_wr_base),
    .cfg_row_len       (cfg_row_len),
    .cfg_stride_chan   (cfg_stride_chan),
    .cfg_chan_num      (cfg_chan_num),
    .mover_start       (mover_start),
    .mover_clr         (mover_clr),
    .mover_row_len     (mover_row_len),
    .mover_base_addr_rd(mover_base_addr_rd),
    .mover_base_addr_wr(mover_base_addr_wr),
    .mover_stride_chan (mover_stride_chan),
    .mover_chan_num    (mover_chan_num),
    .mover_done        (mover_done),
    .tile_valid        (tile_valid),
    .tile_buf          (tile_buf),
    .tile_row          (tile_row),
    .tile_release      (tile_release),
    .busy              (busy),
    .layer_done        (layer_done),
    .err               (err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_start(input logic [7:0] rd, input logic [7:0] wr);
    start_t s;
    s.rd = rd;
    s.wr = wr;
    exp_start.push_back(s);
  endtask

  task automatic push_tile(input logic [7:0] row, input logic b);
    tile_t t;
    t.row  = row;
    t.bidx = b;
    exp_tile.push_back(t);
  endtask

  task automatic do_go(input logic [7:0] rows, input logic [7:0] rd, input logic [7:0] step,
                       input logic [7:0] wr, output int go_cyc);
    tick();
    cfg_num_rows    = rows;
    cfg_rd_base     = rd;
    cfg_row_step    = step;
    cfg_wr_base     = wr;
    cfg_row_len     = 6'(rows + 8'd9);
    cfg_stride_chan = rd ^ 8'h5A;
    cfg_chan_num    = {2'b10, wr};
    cur_len         = cfg_row_len;
    cur_stride      = cfg_stride_chan;
    cur_chan        = cfg_chan_num;
    go              = 1'b1;
    go_cyc          = cyc;
    $display("go rows=%0d rd=%02h step=%02h wr=%02h cyc=%0d", rows, rd, step, wr, cyc);
    tick();
    go = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int at);
    int n = 0;
    at = -1;
    do begin
      tick();
      n++;
    end while (!mover_start && n < budget);
    if (mover_start) at = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no start, expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_layer(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL layer_done_timeout: got no layer_done, expected one within %0d cycles", budget);
    end
  endtask

  // Monitor: every mover_start must match the next queued program.
  initial begin
    start_t s;
    forever begin
      @(negedge clk);
      if (mover_start) begin
        start_cnt++;
        $display("start cyc=%0d rd=%02h wr=%02h", cyc, mover_base_addr_rd, mover_base_addr_wr);
        if (exp_start.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: got start rd=%02h, expected none", mover_base_addr_rd);
        end else begin
          s = exp_start.pop_front();
          chk("start_rd", mover_base_addr_rd, s.rd);
          chk("start_wr", mover_base_addr_wr, s.wr);
          chk("start_cfg", {mover_row_len, mover_stride_chan, mover_chan_num},
              {cur_len, cur_stride, cur_chan});
        end
      end
      if (layer_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        $display("layer_done cyc=%0d", cyc);
      end
    end
  end

  // Mover model: done drops after the start (optionally late) and rises after a latency.
  initial begin
    mover_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mover_start) begin
        repeat (stale_hold) @(negedge clk);
        mover_done = 1'b0;
        repeat (mover_lat) @(negedge clk);
        mover_done = 1'b1;
      end
    end
  end

  // Consumer model: checks the presented tile against the queue, then releases it.
  initial begin
    tile_t t;
    tile_release = 1'b0;
    forever begin
      @(negedge clk);
      if (tile_release) tile_release = 1'b0;
      else if ((auto_rel && tile_valid) || cyc == rel_at_cyc) begin
        if (tile_valid) begin
          $display("release cyc=%0d buf=%0d row=%0d", cyc, tile_buf, tile_row);
          if (exp_tile.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tile_unexpected: got tile row %0d, expected none", tile_row);
          end else begin
            t = exp_tile.pop_front();
            chk("tile_row", tile_row, t.row);
            chk("tile_buf", tile_buf, t.bidx);
          end
        end else $display("release cyc=%0d with no tile", cyc);
        tile_release = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s0, s1, k, d0, c0;

    // Reset state
    tick();
    tick();
    chk("reset_outputs", all_outs, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", all_outs, 64'd0);

    // Three-row layer with prompt releases
    mover_lat = 3;
    auto_rel  = 1'b1;
    push_start(8'h10, 8'h00); push_start(8'h30, 8'h20); push_start(8'h50, 8'h00);
    push_tile(8'd0, 1'b0); push_tile(8'd1, 1'b1); push_tile(8'd2, 1'b0);
    d0 = done_cnt; c0 = start_cnt;
    do_go(8'd3, 8'h10, 8'h20, 8'h00, g);
    chk("busy_after_go", busy, 1'b1);
    wait_start(10, s0);
    chk("go_to_start_latency", s0 - g, 2);
    wait_layer(d0, 200);
    repeat (4) tick();
    chk("l1_done_pulses", done_cnt - d0, 1);
    chk("l1_starts", start_cnt - c0, 3);
    chk("l1_idle", busy, 1'b0);

    // Back-pressure: four rows, no releases until both buffers are full
    auto_rel = 1'b0;
    push_start(8'h00, 8'h40); push_start(8'h08, 8'h60);
    push_tile(8'd0, 1'b0); push_tile(8'd1, 1'b1); push_tile(8'd2, 1'b0); push_tile(8'd3, 1'b1);
    d0 = done_cnt; c0 = start_cnt;
    do_go(8'd4, 8'h00, 8'h08, 8'h40, g);
    repeat (30) tick();
    chk("bp_starts_held", start_cnt - c0, 2);
    chk("bp_busy", busy, 1'b1);
    chk("bp_tile_valid", tile_valid, 1'b1);
    chk("bp_tile_buf", tile_buf, 1'b0);
    push_start(8'h10, 8'h40);
    k = cyc + 1;
    rel_at_cyc = k;
    wait_start(10, s1);
    chk("release_to_start_latency", s1 - k, 2);
    push_start(8'h18, 8'h60);
    auto_rel = 1'b1;
    wait_layer(d0, 200);
    repeat (3) tick();
    chk("bp_total_starts", start_cnt - c0, 4);

    // Commit and release landing on the same edge with one tile held
    auto_rel  = 1'b0;
    mover_lat = 4;
    push_start(8'h20, 8'h80); push_start(8'h24, 8'hA0);
    push_tile(8'd0, 1'b0); push_tile(8'd1, 1'b1);
    d0 = done_cnt;
    do_go(8'd2, 8'h20, 8'h04, 8'h80, g);
    wait_start(10, s0);
    wait_start(30, s1);
    chk("commit_to_next_start", s1 - s0, 6);
    rel_at_cyc = s1 + 4;
    repeat (5) tick();
    chk("sim_tile_valid", tile_valid, 1'b1);
    chk("sim_tile_buf", tile_buf, 1'b1);
    chk("sim_tile_row", tile_row, 8'd1);
    rel_at_cyc = cyc + 1;
    wait_layer(d0, 50);
    chk("sim_done_timing", last_done_cyc - s1, 7);
    tick();
    chk("sim_drained", tile_valid, 1'b0);

    // Stale done: level stays high across the start, only a new edge commits
    stale_hold = 3;
    mover_lat  = 3;
    push_start(8'h33, 8'h05);
    push_tile(8'd0, 1'b0);
    d0 = done_cnt;
    do_go(8'd1, 8'h33, 8'h11, 8'h05, g);
    wait_start(10, s0);
    repeat (2) tick();
    chk("stale_no_commit_early", tile_valid, 1'b0);
    repeat (4) tick();
    chk("stale_no_commit_late", tile_valid, 1'b0);
    tick();
    chk("stale_commit_on_edge", tile_valid, 1'b1);
    stale_hold = 0;
    rel_at_cyc = cyc + 1;
    wait_layer(d0, 50);

    // Spurious release, then a zero-row layer
    tick();
    rel_at_cyc = cyc + 1;
    repeat (2) tick();
    chk("spurious_err", err, 1'b1);
    chk("spurious_state", {busy, tile_valid}, 2'b00);
    d0 = done_cnt; c0 = start_cnt;
    do_go(8'd0, 8'h77, 8'h01, 8'h02, g);
    chk("go_clears_err", err, 1'b0);
    wait_layer(d0, 20);
    chk("zero_rows_done_latency", last_done_cyc - g, 2);
    repeat (5) tick();
    chk("zero_rows_no_start", start_cnt - c0, 0);

    // Abort in WAIT with one tile buffered
    mover_lat = 8;
    push_start(8'h40, 8'h00); push_start(8'h48, 8'h20);
    push_tile(8'd0, 1'b0);
    do_go(8'd2, 8'h40, 8'h08, 8'h00, g);
    wait_start(10, s0);
    wait_start(40, s1);
    repeat (2) tick();
    chk("pre_clr_tile_valid", tile_valid, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_mover_clr", mover_clr, 1'b1);
    chk("clr_busy", busy, 1'b0);
    chk("clr_tile_valid", tile_valid, 1'b0);
    chk("clr_rd_addr", mover_base_addr_rd, 8'h00);
    tick();
    chk("clr_pulse_width", mover_clr, 1'b0);
    exp_start.delete();
    exp_tile.delete();
    repeat (12) tick();

    // Asynchronous reset mid-layer, then a layer whose addresses wrap
    mover_lat = 3;
    auto_rel  = 1'b1;
    push_start(8'h10, 8'h00); push_start(8'h30, 8'h20); push_start(8'h50, 8'h00);
    push_tile(8'd0, 1'b0); push_tile(8'd1, 1'b1); push_tile(8'd2, 1'b0);
    do_go(8'd3, 8'h10, 8'h20, 8'h00, g);
    wait_start(10, s0);
    wait_start(30, s1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs, 64'd0);
    tick();
    rst_n = 1'b1;
    exp_start.delete();
    exp_tile.delete();
    repeat (10) tick();
    push_start(8'hF0, 8'hF0); push_start(8'h10, 8'h10);
    push_tile(8'd0, 1'b0); push_tile(8'd1, 1'b1);
    d0 = done_cnt; c0 = start_cnt;
    do_go(8'd2, 8'hF0, 8'h20, 8'hF0, g);
    wait_layer(d0, 100);
    repeat (3) tick();
    chk("wrap_starts", start_cnt - c0, 2);
    chk("start_queue_empty", exp_start.size(), 0);
    chk("tile_queue_empty", exp_tile.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
